// File: rtl/sdspi_block_reader_uut_if.sv
// sdspi_block_reader_uut_if: byte-level request/status bundle between the block reader and the sdspi host
interface sdspi_block_reader_uut_if;
  logic [4:0]  spi_sclk_speed;
  logic [31:0] spi_block_addr;
  logic        spi_r_block;
  logic        spi_r_multi_block;
  logic        spi_r_byte;
  logic        spi_busy;
  logic        spi_err;
  logic        spi_crc_err;
  logic [7:0]  spi_data_out;
  modport master (
    output spi_sclk_speed, spi_block_addr, spi_r_block, spi_r_multi_block, spi_r_byte,
    input  spi_busy, spi_err, spi_crc_err, spi_data_out
  );
  modport slave (
    input  spi_sclk_speed, spi_block_addr, spi_r_block, spi_r_multi_block, spi_r_byte,
    output spi_busy, spi_err, spi_crc_err, spi_data_out
  );
endinterface

// File: rtl/sdspi_block_reader_uut.sv
// sdspi_block_reader_uut: reads n_blocks 512-byte SD blocks through the sdspi host and folds them into an XOR checksum
module sdspi_block_reader_uut #(
  parameter logic [31:0] BASE_ADDR      = 32'h00000000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FFFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               n_blocks,
  input  logic [4:0]                sclk_speed,
  input  logic                      cmd18,
  output logic                      finish,
  output logic                      err,
  output logic [31:0]               blocks_done,
  output logic [7:0]                checksum,
  sdspi_block_reader_uut_if.master  spi
);
  typedef enum logic [3:0] {IDLE, LATCH, REQ_BLOCK, WAIT_READY, REQ_BYTE, WAIT_BYTE, END_BLOCK, STOP, DONE} st_e;
  st_e         state_q, state_d;
  logic        start_q, cmd18_q, skip_q, err_q, fin_q, rblk_q, rmul_q, rbyte_q;
  logic [31:0] wcnt_q, n_q, done_q, idx_q, addr_q;
  logic [9:0]  cnt_q;
  logic [7:0]  chk_q;
  logic [4:0]  sclk_q;
  logic        busy, to, fault, ok, active;
  assign busy   = spi.spi_busy;
  assign to     = wcnt_q == TIMEOUT_CYCLES;
  assign fault  = spi.spi_err | spi.spi_crc_err | to;
  assign ok     = start & ~fault;
  assign active = state_q inside {LATCH, REQ_BLOCK, WAIT_READY, REQ_BYTE, WAIT_BYTE, END_BLOCK};
  assign finish                = fin_q;
  assign err                   = err_q;
  assign blocks_done           = done_q;
  assign checksum              = chk_q;
  assign spi.spi_sclk_speed    = sclk_q;
  assign spi.spi_block_addr    = addr_q;
  assign spi.spi_r_block       = rblk_q;
  assign spi.spi_r_multi_block = rmul_q;
  assign spi.spi_r_byte        = rbyte_q;
  // next state: any abort (start low, host error, timeout) in an active state funnels into STOP
  always_comb begin
    state_d = state_q;
    if (active && !ok) state_d = STOP;
    else
      case (state_q)
        IDLE:       state_d = (start && !start_q) ? LATCH : IDLE;
        LATCH:      state_d = (n_q == 32'd0) ? DONE : REQ_BLOCK;
        REQ_BLOCK:  state_d = busy ? WAIT_READY : REQ_BLOCK;
        WAIT_READY: state_d = busy ? WAIT_READY : REQ_BYTE;
        REQ_BYTE:   state_d = busy ? WAIT_BYTE : REQ_BYTE;
        WAIT_BYTE:  state_d = busy ? WAIT_BYTE : (!skip_q && cnt_q == 10'd511) ? END_BLOCK : REQ_BYTE;
        END_BLOCK:  state_d = (done_q + 32'd1 == n_q) ? STOP : cmd18_q ? REQ_BYTE : REQ_BLOCK;
        STOP:       state_d = (!busy || to) ? (start ? DONE : IDLE) : STOP;
        DONE:       state_d = start ? DONE : IDLE;
        default:    state_d = IDLE;
      endcase
  end
  // state, counters, checksum and registered host requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      wcnt_q  <= '0;
      n_q     <= '0;
      cmd18_q <= 1'b0;
      sclk_q  <= '0;
      chk_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
      addr_q  <= '0;
      rblk_q  <= 1'b0;
      rmul_q  <= 1'b0;
      rbyte_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      wcnt_q  <= (state_d != state_q) ? '0 : wcnt_q + 32'd1;
      if (state_q == IDLE && state_d == LATCH) begin
        n_q     <= n_blocks;
        cmd18_q <= cmd18;
        sclk_q  <= sclk_speed;
        chk_q   <= '0;
        done_q  <= '0;
        cnt_q   <= '0;
        idx_q   <= '0;
        skip_q  <= 1'b0;
        err_q   <= 1'b0;
      end
      if ((active && start && fault) || (state_q == STOP && to)) err_q <= 1'b1;
      if (state_q == WAIT_BYTE && !busy && ok) begin
        skip_q <= 1'b0;
        if (!skip_q) begin
          chk_q <= chk_q ^ spi.spi_data_out;
          cnt_q <= cnt_q + 10'd1;
        end
      end
      if (state_q == END_BLOCK && ok) begin
        done_q <= done_q + 32'd1;
        cnt_q  <= '0;
        idx_q  <= idx_q + 32'd1;
        skip_q <= cmd18_q;
      end
      if (state_q != IDLE) addr_q <= cmd18_q ? BASE_ADDR : BASE_ADDR + idx_q;
      fin_q   <= state_q == DONE && start;
      rblk_q  <= ok && !cmd18_q && state_q inside {REQ_BLOCK, WAIT_READY, REQ_BYTE, WAIT_BYTE};
      rmul_q  <= ok && cmd18_q && state_q inside {REQ_BLOCK, WAIT_READY, REQ_BYTE, WAIT_BYTE, END_BLOCK};
      rbyte_q <= ok && state_q == REQ_BYTE && !busy;
    end
  end
endmodule

// File: tb/tb_sdspi_block_reader_uut.sv
// tb_sdspi_block_reader_uut: directed checks of the block reader against a behavioural sdspi host
module tb_sdspi_block_reader_uut;
  localparam logic [31:0] BASE = 32'hFFFF_FFFE;
  logic        clk = 1'b0;
  logic        rst, start, cmd18;
  logic [31:0] n_blocks, blocks_done;
  logic [4:0]  sclk_speed;
  logic        finish, err;
  logic [7:0]  checksum;
  sdspi_block_reader_uut_if bus();
  sdspi_block_reader_uut #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst(rst), .start(start), .n_blocks(n_blocks), .sclk_speed(sclk_speed), .cmd18(cmd18),
    .finish(finish), .err(err), .blocks_done(blocks_done), .checksum(checksum), .spi(bus)
  );
  always #5 clk = ~clk;
  int          ntests = 0, nfail = 0;
  int          pat = 0;
  logic        stuck = 1'b0;
  logic [31:0] inj_at = 32'd0, bbase = 32'd0;
  logic [31:0] nbytes = 0, nblk = 0, nmul = 0, nreq = 0, gap = 0, last_gap = 0;
  logic [31:0] a0 = 0, a1 = 0, a2 = 0;
  logic [3:0]  bcnt = 0;
  logic [10:0] bidx = 0;
  logic [7:0]  hdata = 0, bno;
  logic        hcrc = 0, pblk = 0, pmul = 0;
  assign bus.spi_busy     = stuck | (bcnt != 4'd0);
  assign bus.spi_data_out = hdata;
  assign bus.spi_crc_err  = hcrc;
  assign bus.spi_err      = 1'b0;
  assign bno = 8'(nblk - bbase - 32'd1);
  // host model: 6-cycle busy per command, 4-cycle busy per byte, 3-cycle CMD12 when multi drops
  always @(posedge clk) begin
    if (rst) begin
      bcnt <= 0; hcrc <= 0; pblk <= 0; pmul <= 0;
    end else begin
      hcrc <= 1'b0;
      pblk <= bus.spi_r_block;
      pmul <= bus.spi_r_multi_block;
      gap  <= bus.spi_r_block ? 32'd0 : gap + 32'd1;
      if (bus.spi_r_block | bus.spi_r_multi_block | bus.spi_r_byte) nreq <= nreq + 1;
      if (bus.spi_r_block && !pblk) begin
        nblk <= nblk + 1; a0 <= bus.spi_block_addr; a1 <= a0; a2 <= a1; last_gap <= gap;
      end
      if (bus.spi_r_multi_block && !pmul) nmul <= nmul + 1;
      if (bcnt != 0) bcnt <= bcnt - 1;
      else if ((bus.spi_r_block && !pblk) || (bus.spi_r_multi_block && !pmul)) begin
        bcnt <= 6; bidx <= 0;
      end else if (bus.spi_r_byte) begin
        bcnt   <= 4;
        bidx   <= bidx + 1;
        nbytes <= nbytes + 1;
        hdata  <= pat == 0 ? bidx[7:0] : pat == 1 ? bno : pat == 2 ? 8'hA5 : (bidx == 11'd5 ? 8'h5A : 8'h00);
        if (nbytes + 1 == inj_at) hcrc <= 1'b1;
      end
      if (!bus.spi_r_multi_block && pmul) bcnt <= 3;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [31:0] b_bytes, b_blk, b_mul, b_req;
  task automatic run(input logic [31:0] n, input logic m, input int p, input int lim, output int cyc);
    pat = p; n_blocks = n; cmd18 = m; sclk_speed = 5'h13;
    b_bytes = nbytes; b_blk = nblk; b_mul = nmul; b_req = nreq; bbase = nblk;
    @(negedge clk) start = 1'b1;
    cyc = 0;
    while (!finish && cyc < lim) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) begin n_blocks = n + 32'd5; cmd18 = ~m; sclk_speed = 5'h02; end
    end
    check("finish_seen", finish, 1);
  endtask
  task automatic end_run;
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check("finish_fall", finish, 0);
    repeat (10) @(posedge clk);
  endtask
  int cyc;
  initial begin
    rst = 1'b1; start = 1'b0; cmd18 = 1'b0; n_blocks = 0; sclk_speed = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_outs", {finish, err, bus.spi_r_block, bus.spi_r_multi_block, bus.spi_r_byte, bus.spi_sclk_speed}, 0);
    check("rst_bd_chk", {blocks_done, checksum}, 0);
    check("rst_addr", bus.spi_block_addr, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    run(1, 1'b0, 0, 20000, cyc);
    check("s1_bd", blocks_done, 1);
    check("s1_chk", checksum, 8'h00);
    check("s1_err", err, 0);
    check("s1_bytes", nbytes - b_bytes, 512);
    check("s1_addr", a0, BASE);
    check("s1_sclk", bus.spi_sclk_speed, 5'h13);
    end_run();
    run(3, 1'b0, 1, 40000, cyc);
    check("s3_addr0", a2, BASE);
    check("s3_addr1", a1, BASE + 32'd1);
    check("s3_addr2", a0, 32'd0);
    check("s3_rises", nblk - b_blk, 3);
    check("s3_gap", last_gap, 1);
    check("s3_chk", checksum, 8'h00);
    check("s3_bd", blocks_done, 3);
    end_run();
    run(2, 1'b1, 2, 40000, cyc);
    check("m2_rises", nmul - b_mul, 1);
    check("m2_noblk", nblk - b_blk, 0);
    check("m2_bytes", nbytes - b_bytes, 1025);
    check("m2_chk", checksum, 8'h00);
    check("m2_bd", blocks_done, 2);
    check("m2_addr", bus.spi_block_addr, BASE);
    end_run();
    n_blocks = 0; cmd18 = 1'b0; b_req = nreq;
    @(negedge clk) start = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("n0_early", finish, 0);
    @(posedge clk); #1;
    check("n0_fin", finish, 1);
    check("n0_bd", blocks_done, 0);
    check("n0_noreq", nreq - b_req, 0);
    end_run();
    pat = 2; n_blocks = 1; cmd18 = 1'b0; b_bytes = nbytes;
    @(negedge clk) start = 1'b1;
    cyc = 0;
    while (nbytes - b_bytes < 50 && cyc < 2000) begin @(posedge clk); cyc++; end
    check("ab_reached", nbytes - b_bytes >= 50, 1);
    @(negedge clk) start = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("ab_quiet", {finish, err, bus.spi_r_block, bus.spi_r_byte}, 0);
    inj_at = nbytes + 32'd100;
    run(1, 1'b0, 0, 20000, cyc);
    check("crc_err", err, 1);
    check("crc_bd", blocks_done, 0);
    check("crc_bytes", nbytes - b_bytes, 100);
    check("crc_reqs", {bus.spi_r_block, bus.spi_r_multi_block, bus.spi_r_byte}, 0);
    end_run();
    inj_at = 0;
    run(1, 1'b0, 3, 20000, cyc);
    check("rerun_err", err, 0);
    check("rerun_chk", checksum, 8'h5A);
    check("rerun_bd", blocks_done, 1);
    end_run();
    stuck = 1'b1;
    run(1, 1'b0, 0, 400, cyc);
    check("tmo_err", err, 1);
    check("tmo_window", cyc >= 195 && cyc <= 210, 1);
    end_run();
    pat = 0; n_blocks = 1; cmd18 = 1'b0; sclk_speed = 5'h13;
    @(negedge clk) start = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("mid_req", bus.spi_r_block, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outs", {finish, err, bus.spi_r_block, bus.spi_r_multi_block, bus.spi_r_byte, bus.spi_sclk_speed}, 0);
    check("mid_rst_addr", bus.spi_block_addr, 0);
    check("mid_rst_bd_chk", {blocks_done, checksum}, 0);
    @(negedge clk) begin rst = 1'b0; start = 1'b0; stuck = 1'b0; end
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/sdspi_block_reader_uut.md
# sdspi_block_reader_uut

Unit under test driven by the SD autotest controller. On `start` it reads `n_blocks` consecutive 512-byte blocks from the SD card through the shared sdspi host byte interface. It uses either one CMD18 multi-block transfer or repeated single-block reads. It reports completion via `finish`, and also reports a running XOR checksum and the number of blocks read. It sits behind the autotest's host-ownership mux: the autotest owns the host while loading config and writing results, and this block owns it while the test runs.

## Interface
- `BASE_ADDR`, default 32'h00000000: first SD block address read.
- `TIMEOUT_CYCLES`, default 32'h00FFFFFF: maximum `clk` cycles spent in any single host-wait state.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high (clock `clk`). Also driven by the autotest as a soft reset.
- `start`  in  1  level: held high by the autotest for the whole test.
- `n_blocks`  in  32  number of blocks to read; sampled on the start edge.
- `sclk_speed`  in  5  host SCLK divider select; sampled on the start edge.
- `cmd18`  in  1  1 = multi-block mode, 0 = single-block mode; sampled on the start edge.
- `finish`  out  1  test complete (success or error).
- `err`  out  1  abort cause: `spi_err`, `spi_crc_err` or timeout.
- `blocks_done`  out  32  blocks fully read.
- `checksum`  out  8  XOR of every data byte read.
- `spi_sclk_speed`  out  5  latched `sclk_speed`.
- `spi_block_addr`  out  32  block address presented to the host.
- `spi_r_block`, `spi_r_multi_block`, `spi_r_byte`  out  1 each  host requests.
- `spi_busy`, `spi_err`, `spi_crc_err`  in  1 each  host status.
- `spi_data_out`  in  8  byte returned by the host.

## Operation
- **Reset values:** every output is 0 and the state is IDLE.
- **IDLE:** on `start` rising (start=1 and previous start=0), do all of the following, then go to LATCH:
  - latch `n_blocks`, `cmd18` and `sclk_speed`;
  - clear `checksum`, `blocks_done`, the byte counter, the block index and `err`.
- **LATCH:**
  - If latched `n_blocks` == 0, go to DONE.
  - Otherwise go to REQ_BLOCK.
- **REQ_BLOCK:**
  - Assert `spi_r_block` (single mode) or `spi_r_multi_block` (multi mode) and keep it asserted through WAIT_READY and the byte-read states.
  - Wait for `spi_busy`=1, then go to WAIT_READY.
- **WAIT_READY:** wait for `spi_busy`=0, then go to REQ_BYTE.
- **REQ_BYTE:** assert `spi_r_byte` until `spi_busy`=1, then go to WAIT_BYTE.
- **WAIT_BYTE:** when `spi_busy`=0, do all of the following:
  - `checksum ^= spi_data_out`;
  - increment the byte counter (10 bits);
  - if the count is now 512, go to END_BLOCK; otherwise go to REQ_BYTE.
- **END_BLOCK:** `blocks_done++`, byte counter cleared, block index++. Then:
  - if `blocks_done`+1 == `n_blocks`, go to STOP;
  - else in single mode, drop `spi_r_block` for one cycle, then go to REQ_BLOCK;
  - else in multi mode, go to REQ_BYTE. This extra byte request makes the host consume the CRC and the next data token; the host's busy-low then means the next block's first byte is ready, so WAIT_BYTE's first capture is skipped via a `skip_capture` flag.
- **STOP:** deassert all host requests. Wait for `spi_busy`=0 (the host sends CMD12 in multi mode), then go to DONE.
- **DONE:**
  - `finish`=1, held while `start`=1.
  - When `start`=0, clear `finish` and go to IDLE. `err`, `checksum` and `blocks_done` hold until the next start.
- **Block address:**
  - single mode: `spi_block_addr` = `BASE_ADDR` + block index (32-bit, wraps modulo 2^32);
  - multi mode: constant `BASE_ADDR`.
- **Error and timeout:** `spi_err` or `spi_crc_err` high in any active state, or the wait counter reaching `TIMEOUT_CYCLES`, does the following:
  - sets `err`=1;
  - drops all requests;
  - goes to STOP, which still waits for `spi_busy`=0, bounded by the same timeout. If STOP itself times out, go straight to DONE.
- **Wait counter:** cleared on every state change.
- **`start` dropping mid-transfer:** treated as an abort. Go to STOP with `err` unchanged; `finish` is not asserted; then return to IDLE.
- **`rst` mid-transfer:** immediate return to IDLE with all outputs 0. The host is reset separately by the autotest.

## Timing
- All outputs are registered.
- Request outputs follow the state: they assert the cycle after the state is entered.
- Host handshake: a request is held until busy is seen high; the data byte is valid on the first cycle busy is seen low after that.
- `checksum` and `blocks_done` update one cycle after the qualifying busy-low sample.
- `finish` rises one cycle after DONE is entered:
  - with `n_blocks`=0, `finish` rises 3 cycles after the start edge;
  - it falls one cycle after `start`=0.
- `n_blocks`, `cmd18` and `sclk_speed` changes after the start edge are ignored.

## Test plan
- Single block, `n_blocks`=1, `cmd18`=0, host model returning byte i = i[7:0], 4-cycle busy per byte:
  - `finish`=1, `blocks_done`=1, `checksum`=8'h00, `err`=0;
  - exactly 512 `spi_r_byte` handshakes;
  - `spi_block_addr`=`BASE_ADDR`.
- `n_blocks`=3, `cmd18`=0, data = block number:
  - addresses `BASE_ADDR`+0, +1, +2 are seen;
  - `spi_r_block` drops for one cycle between blocks;
  - `checksum`=8'h00^8'h01^8'h02 folded 512 times each = 8'h00;
  - `blocks_done`=3.
- `n_blocks`=2, `cmd18`=1, constant byte 8'hA5:
  - `spi_r_multi_block` stays high for the whole transfer;
  - 1025 byte requests;
  - `checksum`=8'h00, `blocks_done`=2, `finish`=1.
- `n_blocks`=0: `finish` 3 cycles after start, no host requests issued, `blocks_done`=0.
- Inject `spi_crc_err` at byte 100 of block 0:
  - requests drop;
  - `err`=1, `finish`=1, `blocks_done`=0;
  - a second start with a clean host clears `err`.
- Host holds `spi_busy`=1 forever with `TIMEOUT_CYCLES`=100:
  - `err`=1 and `finish`=1 within 210 cycles;
  - asserting `rst` mid-transfer returns all outputs to 0 on the next cycle.
